// File: rtl/scpu_sram_io_resp_pkg.sv
// Shared widths, mode codes and FSM states for the serial SRAM loader responder.
// Every other file of this block imports this package.
package scpu_sram_io_pkg;

    localparam int MEMORY_DATA_WIDTH = 8;
    localparam int MEMORY_ADDR_WIDTH = 9;
    localparam int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
    localparam int CNT_W             = $clog2(REG_BITS_WIDTH);

    typedef enum logic [1:0] {
        MODE_SHIN  = 2'b00,
        MODE_RD    = 2'b01,
        MODE_SHOUT = 2'b10,
        MODE_WR    = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_SHIFT_OUT,
        ST_WR,
        ST_RD_REQ,
        ST_RD_CAP
    } state_e;

    function automatic logic is_shift_mode(input mode_e m);
        return (m == MODE_SHIN) || (m == MODE_SHOUT);
    endfunction

endpackage

// File: rtl/scpu_sram_io_resp_if.sv
// Pad-side control/serial signals plus the SRAM macro port, bundled for the responder.
// slave = the responder itself; master = whatever drives the pads and models the SRAM.
interface scpu_sram_io_resp_if;
    import scpu_sram_io_pkg::*;

    logic [1:0]                   ctrl_mode;
    logic                         ctrl_bgn;
    logic                         load_n;
    logic                         ctrl_si;
    logic                         ctrl_so;
    logic                         ctrl_rdy;
    logic                         sram_cen;
    logic                         sram_wen;
    logic [MEMORY_ADDR_WIDTH-1:0] sram_addr;
    logic [MEMORY_DATA_WIDTH-1:0] sram_din;
    logic [MEMORY_DATA_WIDTH-1:0] sram_dout;

    modport slave (
        input  ctrl_mode, ctrl_bgn, load_n, ctrl_si, sram_dout,
        output ctrl_so, ctrl_rdy, sram_cen, sram_wen, sram_addr, sram_din
    );

    modport master (
        output ctrl_mode, ctrl_bgn, load_n, ctrl_si, sram_dout,
        input  ctrl_so, ctrl_rdy, sram_cen, sram_wen, sram_addr, sram_din
    );

endinterface

// File: rtl/scpu_sram_io_resp_shreg.sv
// 17-bit {addr,data} holding register: LSB-first shift-in, right rotate, low-byte parallel load.
// One operation per cycle; shift has priority over rotate over load; otherwise the value is frozen.
module scpu_serial_shreg
    import scpu_sram_io_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         shift_en_i,
    input  logic                         rot_en_i,
    input  logic                         load_lo_en_i,
    input  logic                         si_i,
    input  logic [MEMORY_DATA_WIDTH-1:0] din_lo_i,
    output logic [REG_BITS_WIDTH-1:0]    q_o
);

    logic [REG_BITS_WIDTH-1:0] shreg_q;
    logic [REG_BITS_WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (shift_en_i) begin
            shreg_d = {si_i, shreg_q[REG_BITS_WIDTH-1:1]};
        end else if (rot_en_i) begin
            shreg_d = {shreg_q[0], shreg_q[REG_BITS_WIDTH-1:1]};
        end else if (load_lo_en_i) begin
            shreg_d[MEMORY_DATA_WIDTH-1:0] = din_lo_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q_o = shreg_q;

endmodule

// File: rtl/scpu_sram_io_resp.sv
// Chip-side responder to the FPGA serial SRAM loader: 17-bit serial shift in/out and one-shot SRAM read/write.
// Shifts take 17 edges, write 1 busy cycle, read 2; ctrl_rdy low while busy and all strobes are dropped then.
module scpu_sram_io_resp
    import scpu_sram_io_pkg::*;
(
    input  logic                csi_clk,
    input  logic                rsi_reset,
    scpu_sram_io_resp_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bgn_q;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic              rdy_q, rdy_d;

    logic              bgn_rise;
    logic              shift_en;
    logic              rot_en;
    logic              cap_en;
    mode_e             mode;
    logic [REG_BITS_WIDTH-1:0] shreg;

    assign mode     = mode_e'(bus.ctrl_mode);
    assign bgn_rise = bus.ctrl_bgn & ~bgn_q;

    scpu_serial_shreg u_shreg (
        .clk          (csi_clk),
        .rst          (rsi_reset),
        .shift_en_i   (shift_en),
        .rot_en_i     (rot_en),
        .load_lo_en_i (cap_en),
        .si_i         (bus.ctrl_si),
        .din_lo_i     (bus.sram_dout),
        .q_o          (shreg)
    );

    // The mode is captured by the state chosen on the start edge, so later ctrl_mode changes are inert.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cen_d    = 1'b1;
        wen_d    = 1'b1;
        shift_en = 1'b0;
        rot_en   = 1'b0;
        cap_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.load_n && is_shift_mode(mode)) begin
                    cnt_d = CNT_W'(REG_BITS_WIDTH - 1);
                    if (mode == MODE_SHIN) begin
                        shift_en = 1'b1;
                        state_d  = ST_SHIFT_IN;
                    end else begin
                        rot_en   = 1'b1;
                        state_d  = ST_SHIFT_OUT;
                    end
                end else if (bgn_rise && mode == MODE_WR) begin
                    cen_d   = 1'b0;
                    wen_d   = 1'b0;
                    state_d = ST_WR;
                end else if (bgn_rise && mode == MODE_RD) begin
                    cen_d   = 1'b0;
                    state_d = ST_RD_REQ;
                end
            end
            ST_SHIFT_IN: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            ST_SHIFT_OUT: begin
                rot_en = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            ST_WR:     state_d = ST_IDLE;
            ST_RD_REQ: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                cap_en  = 1'b1;
                state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bgn_q   <= 1'b0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bgn_q   <= bus.ctrl_bgn;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.ctrl_so   = shreg[0];
    assign bus.ctrl_rdy  = rdy_q;
    assign bus.sram_cen  = cen_q;
    assign bus.sram_wen  = wen_q;
    assign bus.sram_addr = shreg[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
    assign bus.sram_din  = shreg[MEMORY_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_scpu_sram_io_resp.sv
// Bench for scpu_sram_io_resp: SRAM model, access/serial-out scoreboards, directed command sequences.
module tb_scpu_sram_io_resp;
    import scpu_sram_io_pkg::*;

    typedef struct packed {
        logic       wen;
        logic [8:0] addr;
        logic [7:0] din;
    } acc_t;

    logic csi_clk;
    logic rsi_reset;
    scpu_sram_io_resp_if bus();

    scpu_sram_io_resp dut (
        .csi_clk   (csi_clk),
        .rsi_reset (rsi_reset),
        .bus       (bus)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    acc_t acc_q[$];
    bit   so_q[$];
    acc_t acc_got;
    acc_t acc_exp;
    logic [7:0] mem [int];

    initial csi_clk = 1'b0;
    always #5 csi_clk = ~csi_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [7:0] pat(input logic [8:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] model_rd(input logic [8:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : pat(a);
    endfunction

    // Synchronous SRAM: write on the edge that sees cen/wen low, read data valid the following cycle.
    always @(posedge csi_clk) begin
        if (bus.sram_cen == 1'b0) begin
            if (bus.sram_wen == 1'b0) mem[int'(bus.sram_addr)] = bus.sram_din;
            else bus.sram_dout <= model_rd(bus.sram_addr);
        end
    end

    // Every cycle with cen low must match exactly one queued access.
    always @(negedge csi_clk) begin
        if (bus.sram_cen == 1'b0) begin
            chk("sram_unexp", 32'(acc_q.size()), 32'd1);
            if (acc_q.size() != 0) begin
                acc_exp = acc_q.pop_front();
                acc_got = {bus.sram_wen, bus.sram_addr, bus.sram_din};
                chk("sram_access", 32'(acc_got), 32'(acc_exp));
            end
        end
    end

    task automatic tick();
        @(posedge csi_clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [16:0] w);
        chk(tag, 32'({bus.sram_addr, bus.sram_din}), 32'(w));
    endtask

    task automatic shift_in(input logic [16:0] w, input bit disturb);
        bus.ctrl_mode = 2'b00;
        bus.load_n    = 1'b0;
        bus.ctrl_si   = w[0];
        if (disturb) bus.ctrl_bgn = 1'b1;
        tick();
        bus.load_n = 1'b1;
        for (int k = 1; k < 17; k++) begin
            bus.ctrl_si = w[k];
            chk("shin_busy", 32'(bus.ctrl_rdy), 32'd0);
            if (disturb) begin
                if (k == 4) bus.ctrl_bgn = 1'b0;
                if (k == 8) begin
                    bus.load_n   = 1'b0;
                    bus.ctrl_bgn = 1'b1;
                end
                if (k == 9)  bus.load_n    = 1'b1;
                if (k == 10) bus.ctrl_mode = 2'b11;
            end
            tick();
        end
        bus.ctrl_mode = 2'b00;
        bus.ctrl_bgn  = 1'b0;
        chk("shin_done", 32'(bus.ctrl_rdy), 32'd1);
        chk_word("shin_word", w);
    endtask

    task automatic shift_out(input logic [16:0] w);
        for (int k = 0; k < 17; k++) so_q.push_back(w[k]);
        for (int k = 0; k < 17; k++) begin
            chk("shout_bit", 32'(bus.ctrl_so), 32'(so_q.pop_front()));
            if (k == 0) begin
                bus.ctrl_mode = 2'b10;
                bus.load_n    = 1'b0;
            end
            tick();
            bus.load_n = 1'b1;
        end
        bus.ctrl_mode = 2'b00;
        chk("shout_idle", 32'(bus.ctrl_rdy), 32'd1);
        chk_word("shout_kept", w);
    endtask

    task automatic sram_cmd(input logic [1:0] mode, input logic [8:0] a, input logic [7:0] d,
                            input int exp_busy);
        int busy;
        acc_q.push_back(acc_t'({(mode == 2'b01), a, d}));
        bus.ctrl_mode = mode;
        bus.ctrl_bgn  = 1'b1;
        tick();
        bus.ctrl_bgn = 1'b0;
        busy = 0;
        while (bus.ctrl_rdy == 1'b0 && busy < 8) begin
            busy++;
            tick();
        end
        chk("sram_busy_len", 32'(busy), 32'(exp_busy));
        bus.ctrl_mode = 2'b00;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(bus.ctrl_rdy), 32'd1);
        chk({tag, "_cen"}, 32'(bus.sram_cen), 32'd1);
        chk({tag, "_wen"}, 32'(bus.sram_wen), 32'd1);
        chk({tag, "_so"},  32'(bus.ctrl_so),  32'd0);
        chk({tag, "_addr_din"}, 32'({bus.sram_addr, bus.sram_din}), 32'd0);
    endtask

    initial begin
        rsi_reset     = 1'b1;
        bus.ctrl_mode = 2'b00;
        bus.ctrl_bgn  = 1'b0;
        bus.load_n    = 1'b1;
        bus.ctrl_si   = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst_held");
        rsi_reset = 1'b0;
        tick();
        chk_reset_vals("rst_idle");

        // Load, write, read back and shift out the same word.
        shift_in(17'h1A53C, 1'b0);
        sram_cmd(2'b11, 9'h1A5, 8'h3C, 1);
        chk("mem_written", 32'(model_rd(9'h1A5)), 32'h3C);
        shift_in({9'h1A5, 8'h00}, 1'b0);
        sram_cmd(2'b01, 9'h1A5, 8'h00, 2);
        chk_word("rd_cap", 17'h1A53C);
        shift_out(17'h1A53C);

        shift_in({9'h0F3, 8'hFF}, 1'b0);
        sram_cmd(2'b01, 9'h0F3, 8'hFF, 2);
        chk_word("rd_cap_pat", {9'h0F3, pat(9'h0F3)});

        // Simultaneous load/bgn, mid-shift strobes and mode change must all be inert.
        shift_in(17'h0B6E1, 1'b1);
        tick();
        chk("no_restart", 32'(bus.ctrl_rdy), 32'd1);
        chk_word("no_restart_word", 17'h0B6E1);

        // Wrong-mode strobes.
        bus.ctrl_mode = 2'b01;
        bus.load_n    = 1'b0;
        tick();
        bus.load_n = 1'b1;
        chk("wrongmode_load", 32'(bus.ctrl_rdy), 32'd1);
        bus.ctrl_mode = 2'b10;
        bus.ctrl_bgn  = 1'b1;
        tick();
        bus.ctrl_bgn = 1'b0;
        chk("wrongmode_bgn", 32'(bus.ctrl_rdy), 32'd1);
        chk_word("wrongmode_word", 17'h0B6E1);
        bus.ctrl_mode = 2'b00;
        tick();

        // load_n held low: one shift, then a restart once back in IDLE.
        bus.ctrl_mode = 2'b00;
        bus.load_n    = 1'b0;
        bus.ctrl_si   = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        chk("held_idle", 32'(bus.ctrl_rdy), 32'd1);
        chk_word("held_word", 17'h1FFFF);
        tick();
        chk("held_restart", 32'(bus.ctrl_rdy), 32'd0);
        bus.load_n  = 1'b1;
        bus.ctrl_si = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        chk("held_done", 32'(bus.ctrl_rdy), 32'd1);
        chk_word("held_word2", 17'h00001);

        // Reset at bit 8 of a shift-in.
        bus.load_n  = 1'b0;
        bus.ctrl_si = 1'b1;
        tick();
        bus.load_n = 1'b1;
        for (int k = 1; k < 8; k++) tick();
        rsi_reset = 1'b1;
        #1;
        chk_reset_vals("rst_shin");
        @(posedge csi_clk);
        #1;
        rsi_reset = 1'b0;
        tick();
        shift_in(17'h12345, 1'b0);

        // Reset during WR: the write is dropped and cen releases at once.
        shift_in({9'h055, 8'hAB}, 1'b0);
        bus.ctrl_mode = 2'b11;
        bus.ctrl_bgn  = 1'b1;
        tick();
        bus.ctrl_bgn = 1'b0;
        chk("wr_started_cen", 32'(bus.sram_cen), 32'd0);
        rsi_reset = 1'b1;
        #1;
        chk_reset_vals("rst_wr");
        @(posedge csi_clk);
        #1;
        rsi_reset     = 1'b0;
        bus.ctrl_mode = 2'b00;
        tick();
        chk("wr_aborted", 32'(mem.exists(int'(9'h055))), 32'd0);
        shift_in({9'h055, 8'hAB}, 1'b0);
        sram_cmd(2'b11, 9'h055, 8'hAB, 1);
        chk("wr_after_rst", 32'(model_rd(9'h055)), 32'hAB);

        tick();
        tick();
        chk("sram_missing", 32'(acc_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
